// File: rtl/nsa_pkg.sv
// Shared types and constants for the nibble-serial adder.
package nsa_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DONE} nsa_state_t;

   localparam int unsigned NIBBLE = 4;

   function automatic int unsigned nibbles(int unsigned width);
      return width / NIBBLE;
   endfunction

endpackage

// File: rtl/nibble_add4.sv
// Combinational 4-bit ripple adder slice built from 1-bit full adders.
// c3 is the carry into bit 3, exposed for signed-overflow detection.
module nibble_add4 (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       ci,
   output logic [3:0] s,
   output logic       co,
   output logic       c3
);

   logic [4:0] c;

   assign c[0] = ci;

   for (genvar i = 0; i < 4; i++) begin : g_fa
      assign s[i]   = a[i] ^ b[i] ^ c[i];
      assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
   end

   assign co = c[4];
   assign c3 = c[3];

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder that sums one nibble per clock through a single 4-bit slice.
// Optional macro NSA_OVERFLOW_EN adds the registered signed-overflow output ovf.
module nibble_serial_adder
   import nsa_pkg::*;
#(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             busy
`ifdef NSA_OVERFLOW_EN
   ,
   output logic             ovf
`endif
);

   localparam int unsigned N     = nibbles(WIDTH);
   localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

   nsa_state_t       state;
   logic [IDX_W-1:0] idx;
   logic             carry;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;

   logic [3:0] a_nib;
   logic [3:0] b_nib;
   logic [3:0] s_nib;
   logic       co;
   logic       c3;

   assign a_nib = a_q[idx*NIBBLE +: NIBBLE];
   assign b_nib = b_q[idx*NIBBLE +: NIBBLE];

   nibble_add4 u_slice (
      .a  (a_nib),
      .b  (b_nib),
      .ci (carry),
      .s  (s_nib),
      .co (co),
      .c3 (c3)
   );

   // in_ready is gated by rst so it reads 0 throughout reset, not just after it.
   assign in_ready  = (state == IDLE) && !rst;
   assign out_valid = (state == DONE);
   assign busy      = (state != IDLE);

`ifndef NSA_OVERFLOW_EN
   logic unused_c3;
   assign unused_c3 = c3;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         idx   <= '0;
         carry <= 1'b0;
         a_q   <= '0;
         b_q   <= '0;
         sum   <= '0;
         cout  <= 1'b0;
`ifdef NSA_OVERFLOW_EN
         ovf   <= 1'b0;
`endif
      end else begin
         unique case (state)
            IDLE: begin
               if (in_valid) begin
                  a_q   <= a;
                  b_q   <= b;
                  carry <= cin;
                  idx   <= '0;
                  state <= RUN;
               end
            end
            RUN: begin
               sum[idx*NIBBLE +: NIBBLE] <= s_nib;
               carry <= co;
               idx   <= idx + IDX_W'(1);
               if (idx == LAST) begin
                  cout  <= co;
`ifdef NSA_OVERFLOW_EN
                  ovf   <= c3 ^ co;
`endif
                  state <= DONE;
               end
            end
            DONE: begin
               if (out_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder (WIDTH=16) using an expected-result queue.
module tb_nibble_serial_adder;

   localparam int W = 16;
   localparam int N = W / 4;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         cin = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] sum;
   logic         cout;
   logic         busy;
`ifdef NSA_OVERFLOW_EN
   logic         ovf;
`endif

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   logic [17:0] exp_q[$];   // {ovf, cout, sum}
   int acc_q[$];

   nibble_serial_adder #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .busy      (busy)
`ifdef NSA_OVERFLOW_EN
      ,
      .ovf       (ovf)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   // An accept happens at the next rising edge when both are high here.
   always @(negedge clk) if (in_valid && in_ready && !rst) acc_q.push_back(cyc);

   function automatic logic [17:0] model(logic [W-1:0] x, logic [W-1:0] y, logic c);
      logic [16:0] t;
      logic        v;
      t = {1'b0, x} + {1'b0, y} + 17'(c);
      v = (x[W-1] == y[W-1]) && (t[W-1] != x[W-1]);
      return {v, t};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_op(logic [W-1:0] x, logic [W-1:0] y, logic c);
      a = x;
      b = y;
      cin = c;
      in_valid = 1'b1;
      exp_q.push_back(model(x, y, c));
   endtask

   task automatic wait_valid(output int lat);
      lat = 0;
      while (!out_valid && lat < 40) begin
         step();
         lat++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #2;
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
      checks++; if ({cout, sum} !== 17'h0) begin failures++; $display("FAIL reset_sum got=%b_%h want=0_0000", cout, sum); end
`ifdef NSA_OVERFLOW_EN
      checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b want=0", ovf); end
`endif
      step();
      step();
      rst = 1'b0;
      #1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL post_reset_in_ready got=%b want=1", in_ready); end
   endtask

   task automatic test_basic();
      int lat;
      logic [17:0] e;
      push_op(16'hFFFF, 16'h0001, 1'b0);
      step();
      in_valid = 1'b0;
      a = 16'h5A5A;
      b = 16'hA5A5;
      cin = 1'b1;
      wait_valid(lat);
      checks++; if (lat != N) begin failures++; $display("FAIL basic_latency got=%0d want=%0d", lat, N); end
      e = exp_q.pop_front();
      checks++; if ({cout, sum} !== e[16:0]) begin failures++; $display("FAIL basic_result got=%b_%h want=%b_%h", cout, sum, e[16], e[15:0]); end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL basic_handshake got valid=%b ready=%b want valid=0 ready=1", out_valid, in_ready); end
   endtask

   task automatic test_busy();
      int lat;
      int bad;
      logic [17:0] e;
      push_op(16'h1234, 16'h4321, 1'b1);
      step();
      in_valid = 1'b0;
      lat = 0;
      bad = 0;
      while (!out_valid && lat < 40) begin
         if (busy !== 1'b1 || in_ready !== 1'b0) bad++;
         step();
         lat++;
      end
      checks++; if (bad != 0) begin failures++; $display("FAIL busy_in_run got=%0d_bad_cycles want=0", bad); end
      checks++; if (lat != N) begin failures++; $display("FAIL busy_latency got=%0d want=%0d", lat, N); end
      step();
      checks++; if (busy !== 1'b1 || out_valid !== 1'b1) begin failures++; $display("FAIL busy_in_done got busy=%b valid=%b want 1 1", busy, out_valid); end
      e = exp_q.pop_front();
      checks++; if ({cout, sum} !== e[16:0]) begin failures++; $display("FAIL busy_result got=%b_%h want=%b_%h", cout, sum, e[16], e[15:0]); end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL busy_after_handshake got=%b want=0", busy); end
   endtask

   task automatic test_backpressure();
      int lat;
      int bad;
      logic [17:0] e;
      push_op(16'h00FF, 16'h0001, 1'b0);
      step();
      in_valid = 1'b0;
      wait_valid(lat);
      checks++; if (!out_valid) begin failures++; $display("FAIL bp_timeout got=%b want=1", out_valid); end
      e = exp_q.pop_front();
      bad = 0;
      for (int i = 0; i < 3; i++) begin
         a = 16'hAAAA;
         b = 16'hAAAA;
         in_valid = (i != 1);
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum !== e[15:0] || cout !== e[16]) bad++;
         step();
      end
      in_valid = 1'b0;
      checks++; if (bad != 0) begin failures++; $display("FAIL bp_hold got=%0d_bad_cycles want=0", bad); end
      checks++; if ({cout, sum} !== e[16:0]) begin failures++; $display("FAIL bp_result got=%b_%h want=%b_%h", cout, sum, e[16], e[15:0]); end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      step();
      step();
      checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin failures++; $display("FAIL bp_no_capture got busy=%b valid=%b want 0 0", busy, out_valid); end
   endtask

   task automatic test_reset_mid();
      int lat;
      logic [17:0] e;
      push_op(16'h1111, 16'h2222, 1'b0);
      step();
      in_valid = 1'b0;
      step();
      rst = 1'b1;
      #1;
      void'(exp_q.pop_front());
      checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL midreset_ctrl got valid=%b busy=%b want 0 0", out_valid, busy); end
      checks++; if (sum !== 16'h0000 || cout !== 1'b0) begin failures++; $display("FAIL midreset_sum got=%b_%h want=0_0000", cout, sum); end
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL midreset_in_ready got=%b want=0", in_ready); end
      step();
      rst = 1'b0;
      #1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL midreset_release got=%b want=1", in_ready); end
      push_op(16'h0002, 16'h0003, 1'b0);
      step();
      in_valid = 1'b0;
      wait_valid(lat);
      e = exp_q.pop_front();
      checks++; if (!out_valid || {cout, sum} !== e[16:0]) begin failures++; $display("FAIL midreset_fresh got=%b_%h want=%b_%h", cout, sum, e[16], e[15:0]); end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

`ifdef NSA_OVERFLOW_EN
   task automatic test_overflow();
      int lat;
      logic [17:0] e;
      logic [W-1:0] xs[2] = '{16'h7FFF, 16'hFFFF};
      for (int i = 0; i < 2; i++) begin
         push_op(xs[i], 16'h0001, 1'b0);
         step();
         in_valid = 1'b0;
         wait_valid(lat);
         e = exp_q.pop_front();
         checks++; if (!out_valid || {ovf, cout, sum} !== e) begin failures++; $display("FAIL ovf_%0d got=%b_%b_%h want=%b_%b_%h", i, ovf, cout, sum, e[17], e[16], e[15:0]); end
         out_ready = 1'b1;
         step();
         out_ready = 1'b0;
      end
   endtask
`endif

   task automatic test_back_to_back();
      int seen;
      int lim;
      logic [17:0] e;
      acc_q.delete();
      out_ready = 1'b1;
      push_op(16'hBEEF, 16'h1357, 1'b1);
      step();
      push_op(16'h8001, 16'h8FFF, 1'b0);
      seen = 0;
      lim = 0;
      while (seen < 2 && lim < 40) begin
         if (acc_q.size() >= 2) in_valid = 1'b0;
         if (out_valid) begin
            e = exp_q.pop_front();
            checks++; if ({cout, sum} !== e[16:0]) begin failures++; $display("FAIL b2b_result_%0d got=%b_%h want=%b_%h", seen, cout, sum, e[16], e[15:0]); end
            seen++;
         end
         step();
         lim++;
      end
      in_valid = 1'b0;
      out_ready = 1'b0;
      checks++; if (seen != 2) begin failures++; $display("FAIL b2b_count got=%0d want=2", seen); end
      checks++;
      if (acc_q.size() != 2 || acc_q[1] - acc_q[0] != N + 2) begin
         failures++;
         $display("FAIL b2b_interval got=%0d accepts gap=%0d want=2 accepts gap=%0d", acc_q.size(),
                  (acc_q.size() >= 2) ? acc_q[1] - acc_q[0] : -1, N + 2);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_busy();
      test_backpressure();
      test_reset_mid();
`ifdef NSA_OVERFLOW_EN
      test_overflow();
`endif
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/nibble_serial_adder.md
# nibble_serial_adder

Multi-cycle wide-operand adder that accepts two WIDTH-bit operands over a valid/ready handshake and adds them one nibble per clock, using a single combinational 4-bit ripple adder slice. It registers the carry between slices and accumulates the partial sums, then presents the full-width result on an output valid/ready handshake. It sits directly upstream of the 4-bit adder slice and sequences every operand nibble and carry into it, trading latency for area in wide datapaths.

## Interface
- WIDTH, 16: operand and result width in bits; must be a multiple of 4 and ≥ 8.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; asynchronous, active-high.
- in_valid  input  1  operands valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in to nibble 0.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  result, a+b+cin mod 2^WIDTH.
- cout  output  1  carry out of the MSB.
- busy  output  1  high in RUN or DONE.
- ovf  output  1  signed overflow; present only with NSA_OVERFLOW_EN.

## Operation
- Uses a 3-state FSM: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE: in_ready=1. On in_valid&&in_ready, capture a, b, and cin into operand registers, clear the nibble index, and go to RUN.
- RUN: on each cycle, feed nibble idx of A and B plus the carry register to the slice.
  - Write the slice sum into sum[4*idx+3:4*idx].
  - Load the slice carry-out into the carry register.
  - Increment idx.
- RUN exit: after nibble N-1 (N=WIDTH/4), load cout from the final carry and go to DONE.
- DONE: out_valid=1. sum and cout are held stable. On out_ready, go to IDLE.
- in_ready is low in RUN and DONE. in_valid is ignored there, and operands are not captured.
- out_valid is high only in DONE. A result is never dropped or overwritten before out_ready.
- A new operand is not accepted in the same cycle as the out_ready handshake. The block is in IDLE the following cycle.
- Inputs a, b, and cin may change freely after the accept edge.
- Reset values: in_ready=0 while rst is high, then 1 in IDLE. out_valid=0, sum=0, cout=0, busy=0, ovf=0. idx, carry, and operand registers are 0.
- Reset asserted mid-RUN or in DONE aborts immediately and asynchronously. All outputs take reset values, and any in-flight result is discarded.

## Timing
- Accept edge at cycle T. RUN occupies cycles T+1..T+N.
- out_valid rises after the edge ending cycle T+N, which gives a latency of N cycles from accept to out_valid.
- For WIDTH=16, latency is 4 cycles.
- Minimum issue interval is N+2 cycles: N in RUN, 1 in DONE with out_ready=1, and 1 in IDLE.
- Backpressure: DONE persists indefinitely while out_ready=0.
- The slice is purely combinational, so the critical path is the 4-bit ripple plus the nibble mux.

## Configuration
- NSA_OVERFLOW_EN:
  - When defined, adds output ovf.
  - ovf is registered with cout on the final RUN cycle as the carry into bit WIDTH-1 XOR the carry out of bit WIDTH-1.
  - ovf resets to 0 and is held in DONE.
  - When undefined, the ovf port and its logic are absent. All other behaviour is identical.

## Structure
- Package nsa_pkg:
  - state typedef nsa_state_t {IDLE, RUN, DONE}.
  - Constant NIBBLE=4.
  - Function nibbles(WIDTH) returning WIDTH/4.
- Sub-module nibble_add4:
  - Combinational 4-bit ripple adder built from 1-bit full adders.
  - Inputs: a[3:0], b[3:0], ci. Outputs: s[3:0], co, and c3 (the carry into bit 3, used for ovf).
  - Instantiated exactly once.

## Test plan
- WIDTH=16, a=16'hFFFF, b=16'h0001, cin=0 → sum=16'h0000, cout=1. out_valid is high exactly 4 cycles after the accept edge.
- a=16'h1234, b=16'h4321, cin=1 → sum=16'h5556, cout=0. busy is high from T+1 until the out_ready handshake.
- Backpressure: a=16'h00FF, b=16'h0001. Hold out_ready=0 for 3 cycles in DONE → sum=16'h0100 stays stable and out_valid stays 1. Meanwhile in_ready=0, and pulsing in_valid with a=16'hAAAA is not captured.
- Reset mid-operation: assert rst during the 2nd RUN cycle → out_valid, sum, and busy go to 0 without a clock edge. After release, in_ready=1 and a fresh add of 16'h0002+16'h0003 gives 16'h0005.
- With NSA_OVERFLOW_EN, a=16'h7FFF, b=16'h0001 → sum=16'h8000, cout=0, ovf=1. With a=16'hFFFF, b=16'h0001 → ovf=0, cout=1.
- Back-to-back: two transactions with in_valid held high and out_ready=1 → second accept occurs exactly N+2 cycles after the first, and both results are correct.
